mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 18 +
 rtl/mem_loader_if.sv | 33 +++
 rtl/mem_loader_word_fifo.sv | 56 +++++
 rtl/mem_loader.sv | 108 ++++++++++
 tb/tb_mem_loader.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and default constants for the mem_loader slice.
package mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    localparam int DEF_DEPTH        = 4;
    localparam int DEF_WRITE_CYCLES = 2;
    localparam int DEF_XFER_CYCLES  = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Producer, address-load and memory-stage signals of mem_loader.
// in_valid/in_ready: a word moves on a rising edge where both are high; in_ready never depends on in_valid.
interface mem_loader_if #(
    parameter int DEPTH = mem_loader_pkg::DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          addr_load;
    logic [15:0]   addr_base;
    logic [15:0]   mem_address;
    logic [15:0]   mem_data_in;
    logic          mem_enable;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          word_done;
    logic [15:0]   xfer_count;

    modport master (
        output in_valid, in_data, addr_load, addr_base,
        input  in_ready, mem_address, mem_data_in, mem_enable,
        input  busy, fifo_count, word_done, xfer_count
    );

    modport slave (
        input  in_valid, in_data, addr_load, addr_base,
        output in_ready, mem_address, mem_data_in, mem_enable,
        output busy, fifo_count, word_done, xfer_count
    );

endinterface

// File: rtl/mem_loader_word_fifo.sv
// Synchronous 16-bit word FIFO; DEPTH must be a power of two so pointers wrap naturally.
module word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [15:0]                i_data,
    input  logic                       i_pop,
    output logic [15:0]                o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Fullness is judged before any same-cycle pop, so a full FIFO refuses a push outright.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_loader.sv
// Drains queued command words into a two-phase memory stage: a write window (enable low) then a copy window (enable high).
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int WRITE_CYCLES = DEF_WRITE_CYCLES,
    parameter int XFER_CYCLES  = DEF_XFER_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    mem_loader_if.slave  bus,
    output state_t       o_dbg_state
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(max_int(WRITE_CYCLES, XFER_CYCLES) + 1);
    localparam logic [PW-1:0] W_LAST = PW'(WRITE_CYCLES - 1);
    localparam logic [PW-1:0] X_LAST = PW'(XFER_CYCLES - 1);

    state_t        r_state;
    logic [PW-1:0] r_phase;
    logic [15:0]   r_wptr;
    logic [15:0]   r_mem_address;
    logic [15:0]   r_mem_data_in;
    logic          r_mem_enable;
    logic          r_word_done;
    logic [15:0]   r_xfer_count;

    logic [15:0]   w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    assign w_pop = (r_state == ST_IDLE) & ~w_empty;

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.in_valid),
        .i_data  (bus.in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Address and data are only captured on the pop, so they stay frozen through both windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_wptr        <= '0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_enable  <= 1'b1;
            r_word_done   <= 1'b0;
            r_xfer_count  <= '0;
        end else begin
            r_word_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_mem_data_in <= w_head;
                        r_mem_address <= r_wptr;
                        r_mem_enable  <= 1'b0;
                        r_phase       <= '0;
                        r_state       <= ST_WRITE;
                    end else if (bus.addr_load) begin
                        r_wptr <= bus.addr_base;
                    end
                end
                ST_WRITE: begin
                    if (r_phase == W_LAST) begin
                        r_phase      <= '0;
                        r_mem_enable <= 1'b1;
                        r_state      <= ST_XFER;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (r_phase == X_LAST) begin
                        r_phase      <= '0;
                        r_word_done  <= 1'b1;
                        r_xfer_count <= r_xfer_count + 16'd1;
                        r_wptr       <= r_wptr + 16'd1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.fifo_count  = w_count;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data_in = r_mem_data_in;
    assign bus.mem_enable  = r_mem_enable;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.word_done   = r_word_done;
    assign bus.xfer_count  = r_xfer_count;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized and directed bench for mem_loader against a timeline-based reference model.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int DEPTH = 4;
    localparam int WC    = 2;
    localparam int XC    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_loader_if #(.DEPTH(DEPTH)) bus ();
    state_t dbg_state;

    mem_loader #(
        .DEPTH        (DEPTH),
        .WRITE_CYCLES (WC),
        .XFER_CYCLES  (XC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    // m_rem counts cycles left in the current word's WC+XC window; zero means idle.
    logic [15:0] m_q [$];
    logic [15:0] m_ptr;
    logic [15:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] m_xcount;
    int          m_rem;
    bit          m_done;

    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit accept;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_ptr    = '0;
            m_addr   = '0;
            m_data   = '0;
            m_xcount = '0;
            m_rem    = 0;
            m_done   = 0;
        end else begin
            accept = bus.in_valid && (m_q.size() < DEPTH);
            m_done = 0;
            if (m_rem == 0) begin
                if (m_q.size() > 0) begin
                    m_data = m_q.pop_front();
                    m_addr = m_ptr;
                    m_rem  = WC + XC;
                    exp_q.push_back({m_addr, m_data});
                end else if (bus.addr_load) begin
                    m_ptr = bus.addr_base;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done   = 1;
                    m_xcount = m_xcount + 16'd1;
                    m_ptr    = m_ptr + 16'd1;
                end
            end
            if (accept) m_q.push_back(bus.in_data);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e;
        check("in_ready",    32'(bus.in_ready),    32'(m_q.size() != DEPTH));
        check("fifo_count",  32'(bus.fifo_count),  32'(m_q.size()));
        check("mem_enable",  32'(bus.mem_enable),  32'(!(m_rem > XC)));
        check("mem_address", 32'(bus.mem_address), 32'(m_addr));
        check("mem_data_in", 32'(bus.mem_data_in), 32'(m_data));
        check("busy",        32'(bus.busy),        32'(m_rem > 0));
        check("word_done",   32'(bus.word_done),   32'(m_done));
        check("xfer_count",  32'(bus.xfer_count),  32'(m_xcount));
        check("dbg_idle",    32'(dbg_state == ST_IDLE), 32'(m_rem == 0));
        if (bus.word_done) begin
            obs_q.push_back({bus.mem_address, bus.mem_data_in});
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", {bus.mem_address, bus.mem_data_in}, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.addr_load = 1'b0;
        bus.addr_base = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic push_word(input logic [15:0] d);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("push_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while ((bus.busy || bus.fifo_count != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(bus.busy || bus.fifo_count != 0), 32'd0);
    endtask

    task automatic wait_xfer(input int budget);
        int n = 0;
        while (!(bus.busy && bus.mem_enable) && n < budget) begin
            tick();
            n++;
        end
        check("xfer_timeout", 32'(bus.busy && bus.mem_enable), 32'd1);
    endtask

    task automatic wait_not_busy(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] w [6];
        int k;
        int guard;
        bit saw_full;

        rst = 1'b1;
        idle_inputs();
        do_reset();

        check("rst_mem_enable",  32'(bus.mem_enable),  32'd1);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_mem_data",    32'(bus.mem_data_in), 32'd0);
        check("rst_fifo_count",  32'(bus.fifo_count),  32'd0);
        check("rst_xfer_count",  32'(bus.xfer_count),  32'd0);
        check("rst_in_ready",    32'(bus.in_ready),    32'd1);

        // Single word: 2 cycles enable low, 3 high, then done.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3CA5;
        tick();
        bus.in_valid = 1'b0;
        tick();
        for (int i = 0; i < WC + XC; i++) begin
            check("single_enable", 32'(bus.mem_enable), (i < WC) ? 32'd0 : 32'd1);
            check("single_addr",   32'(bus.mem_address), 32'h0000);
            check("single_data",   32'(bus.mem_data_in), 32'h3CA5);
            check("single_nodone", 32'(bus.word_done), 32'd0);
            tick();
        end
        check("single_done", 32'(bus.word_done),  32'd1);
        check("single_xcnt", 32'(bus.xfer_count), 32'd1);
        tick();
        check("single_idle_enable", 32'(bus.mem_enable), 32'd1);

        // Fill: keep offering until all words are taken; FIFO must go full.
        do_reset();
        for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
        k = 0;
        guard = 0;
        saw_full = 0;
        while (k < 6 && guard < 200) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[k];
            if (!bus.in_ready) saw_full = 1;
            if (bus.in_ready) k++;
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        check("fill_full_seen", 32'(saw_full), 32'd1);
        check("fill_all_taken", 32'(k), 32'd6);
        wait_drained(200);
        check("fill_n_words", 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            check("fill_order", obs_q[i], {16'(i), w[i]});
        end

        // Wrap of the write pointer.
        do_reset();
        bus.addr_load = 1'b1;
        bus.addr_base = 16'hFFFF;
        tick();
        idle_inputs();
        push_word(16'h1111);
        push_word(16'h2222);
        wait_drained(100);
        check("wrap_n_words", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            check("wrap_addr0", 32'(obs_q[0][31:16]), 32'hFFFF);
            check("wrap_addr1", 32'(obs_q[1][31:16]), 32'h0000);
        end

        // Address load during XFER is dropped.
        do_reset();
        push_word(16'hA001);
        push_word(16'hA002);
        wait_xfer(50);
        bus.addr_load = 1'b1;
        bus.addr_base = 16'h0100;
        tick();
        idle_inputs();
        wait_drained(100);
        push_word(16'hA003);
        wait_drained(100);
        check("ign_n_words", 32'(obs_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            check("ign_addr", 32'(obs_q[i][31:16]), 32'(i));
        end

        // Reset mid-XFER with two words queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hB000 + 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_xfer(50);
        check("midrst_queued", 32'(bus.fifo_count), 32'd2);
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.addr_load = 1'b1;
        bus.addr_base = 16'h5555;
        tick();
        rst = 1'b0;
        idle_inputs();
        check("midrst_count",  32'(bus.fifo_count),  32'd0);
        check("midrst_enable", 32'(bus.mem_enable),  32'd1);
        check("midrst_addr",   32'(bus.mem_address), 32'd0);
        check("midrst_nodone", 32'(bus.word_done),   32'd0);
        obs_q.delete();
        tick();
        push_word(16'hC0DE);
        wait_drained(100);
        check("midrst_next_addr", (obs_q.size() > 0) ? 32'(obs_q[0][31:16]) : 32'hDEAD, 32'd0);

        // Simultaneous push and pop with two words queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hD000 + 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_xfer(50);
        wait_not_busy(50);
        check("pp_before", 32'(bus.fifo_count), 32'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hD003;
        tick();
        bus.in_valid = 1'b0;
        check("pp_after", 32'(bus.fifo_count), 32'd2);
        wait_drained(200);

        // Randomized traffic with occasional address loads and resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 55);
            bus.in_data   = 16'($urandom);
            bus.addr_load = ($urandom_range(0, 99) < 8);
            bus.addr_base = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            rst           = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        wait_drained(200);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
